// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the alu_pipe block
//
// Purpose: operation codes, FSM state encoding and the opcode width used by
//          alu_pipe, alu_pipe_if and alu_shift_mul.
// Ports:   none (package).
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ZERO = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_XOR  = 3'b101,
      OP_MUL  = 3'b110,
      OP_RSVD = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - command/result handshake bundle for alu_pipe
//
// Purpose: groups the operand-side and result-side valid/ready channels.
// Signals: in_valid/in_ready/op/a/b/ci (command), out_valid/out_ready/
//          result/result_hi/co/zero/ovf (result), acc_sel when
//          ALU_PIPE_ACCUM_EN is defined.
// Modports: master = operand source + result consumer, slave = the ALU.
interface alu_pipe_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             co;
   logic             zero;
   logic             ovf;
`ifdef ALU_PIPE_ACCUM_EN
   logic             acc_sel;

   modport master (
      output in_valid, op, a, b, ci, out_ready, acc_sel,
      input  in_ready, out_valid, result, result_hi, co, zero, ovf
   );

   modport slave (
      input  in_valid, op, a, b, ci, out_ready, acc_sel,
      output in_ready, out_valid, result, result_hi, co, zero, ovf
   );
`else
   modport master (
      output in_valid, op, a, b, ci, out_ready,
      input  in_ready, out_valid, result, result_hi, co, zero, ovf
   );

   modport slave (
      input  in_valid, op, a, b, ci, out_ready,
      output in_ready, out_valid, result, result_hi, co, zero, ovf
   );
`endif
endinterface

// File: rtl/alu_shift_mul.sv
// rtl/alu_shift_mul.sv - iterative unsigned shift-add multiplier
//
// Purpose: computes a*b over exactly WIDTH cycles, one multiplier bit each.
// Ports:   clk, rst_n (async active-low), start (load a/b, begin),
//          a/b (operands), busy (iterating), done (final iteration happens
//          on this edge), prod (product value after this cycle's iteration).
module alu_shift_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand;
   // Upper half accumulates the partial product, lower half starts as the
   // multiplier and is shifted out one bit per iteration.
   logic [2*WIDTH-1:0] pp;
   logic [WIDTH:0]     hi_sum;
   logic [2*WIDTH-1:0] pp_next;

   assign hi_sum  = {1'b0, pp[2*WIDTH-1:WIDTH]} + (pp[0] ? {1'b0, mcand} : '0);
   assign pp_next = {hi_sum, pp[WIDTH-1:1]};

   // prod is the look-ahead value so the caller can capture the full
   // product on the same edge as the last iteration.
   assign prod = pp_next;
   assign done = busy && (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         mcand <= '0;
         pp    <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         cnt   <= '0;
         mcand <= a;
         pp    <= {{WIDTH{1'b0}}, b};
         busy  <= 1'b1;
      end else if (busy) begin
         pp  <= pp_next;
         cnt <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked WIDTH-bit ALU with registered result and flags
//
// Purpose: accepts a command on the in_* channel, computes ZERO/ADD/SUB/AND/
//          OR/XOR in one cycle or MUL over WIDTH cycles, and presents the
//          registered result on the out_* channel until consumed.
// Ports:   clk, rst_n (async active-low), bus (alu_pipe_if.slave).
// Config:  ALU_PIPE_ACCUM_EN adds acc_sel, which substitutes the last
//          delivered low result word for operand A.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus
);
   alu_state_e         state;
   logic               out_valid_r;
   logic [WIDTH-1:0]   result_r;
   logic [WIDTH-1:0]   result_hi_r;
   logic               co_r;
   logic               zero_r;
   logic               ovf_r;

   alu_op_e            op_in;
   logic               in_ready;
   logic               accept;
   logic [WIDTH-1:0]   a_eff;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   n_result;
   logic               n_co;
   logic               n_ovf;
   logic               n_zero;

   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign op_in    = alu_op_e'(bus.op);
   assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

`ifdef ALU_PIPE_ACCUM_EN
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_src;

   // A delivery on this very edge is already the "last delivered" result.
   assign acc_src = (out_valid_r && bus.out_ready) ? result_r : acc;
   assign a_eff   = bus.acc_sel ? acc_src : bus.a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (out_valid_r && bus.out_ready) begin
         acc <= result_r;
      end
   end
`else
   assign a_eff = bus.a;
`endif

   // SUB is a + ~b + ci; the inverted operand also feeds the overflow test.
   assign b_eff = (op_in == OP_SUB) ? ~bus.b : bus.b;
   assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.ci};

   always_comb begin
      n_result = '0;
      n_co     = 1'b0;
      n_ovf    = 1'b0;
      case (op_in)
         OP_ADD, OP_SUB: begin
            n_result = sum[WIDTH-1:0];
            n_co     = sum[WIDTH];
            n_ovf    = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (sum[WIDTH-1] != a_eff[WIDTH-1]);
         end
         OP_AND:  n_result = a_eff & bus.b;
         OP_OR:   n_result = a_eff | bus.b;
         OP_XOR:  n_result = a_eff ^ bus.b;
         default: n_result = '0;
      endcase
   end

   assign n_zero    = (n_result == '0);
   assign mul_start = accept && (op_in == OP_MUL);

   alu_shift_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .a     (a_eff),
      .b     (bus.b),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         result_hi_r <= '0;
         co_r        <= 1'b0;
         zero_r      <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  result_hi_r <= '0;
                  if (op_in == OP_MUL) begin
                     // Clear everything so nothing stale is visible while
                     // the multiply runs.
                     state       <= ST_MUL;
                     out_valid_r <= 1'b0;
                     result_r    <= '0;
                     co_r        <= 1'b0;
                     zero_r      <= 1'b0;
                     ovf_r       <= 1'b0;
                  end else begin
                     state       <= ST_DONE;
                     out_valid_r <= 1'b1;
                     result_r    <= n_result;
                     co_r        <= n_co;
                     zero_r      <= n_zero;
                     ovf_r       <= n_ovf;
                  end
               end else if ((state == ST_DONE) && bus.out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_r <= 1'b0;
               end
            end
            ST_MUL: begin
               if (mul_busy && mul_done) begin
                  state       <= ST_DONE;
                  out_valid_r <= 1'b1;
                  result_r    <= mul_prod[WIDTH-1:0];
                  result_hi_r <= mul_prod[2*WIDTH-1:WIDTH];
                  co_r        <= |mul_prod[2*WIDTH-1:WIDTH];
                  zero_r      <= (mul_prod[WIDTH-1:0] == '0);
                  ovf_r       <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.result_hi = result_hi_r;
   assign bus.co        = co_r;
   assign bus.zero      = zero_r;
   assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (WIDTH=8)
module tb_alu_pipe;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   alu_pipe_if #(.WIDTH(8)) bus ();

   alu_pipe #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic c);
      bus.in_valid = v;
      bus.op       = o;
      bus.a        = x;
      bus.b        = y;
      bus.ci       = c;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.out_valid, bus.result, bus.result_hi, bus.co, bus.zero, bus.ovf} !== 20'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b r=%h hi=%h co=%b z=%b ovf=%b, want all 0",
                  bus.out_valid, bus.result, bus.result_hi, bus.co, bus.zero, bus.ovf);
      end
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      @(negedge clk);
      drive(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b0);
      bus.out_ready = 1'b0;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL add_accept: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.result, bus.co, bus.zero, bus.ovf, bus.result_hi} !==
          {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL add_ff_01: got v=%b r=%h co=%b z=%b ovf=%b hi=%h want v=1 r=00 co=1 z=1 ovf=0 hi=00",
                  bus.out_valid, bus.result, bus.co, bus.zero, bus.ovf, bus.result_hi);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL add_release: got out_valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_sub();
      @(negedge clk);
      drive(1'b1, OP_SUB, 8'h80, 8'h01, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero, bus.result_hi} !==
          {1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL sub_80_01: got v=%b r=%h co=%b ovf=%b z=%b hi=%h want v=1 r=7f co=1 ovf=1 z=0 hi=00",
                  bus.out_valid, bus.result, bus.co, bus.ovf, bus.zero, bus.result_hi);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_logic_ops();
      logic [2:0] ops [4]  = '{OP_AND, OP_OR, OP_XOR, OP_ZERO};
      logic [7:0] exps [4] = '{8'h0C, 8'h3F, 8'h33, 8'h00};
      logic       zexp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, ops[i], 8'h3C, 8'h0F, 1'b1);
         @(negedge clk);
         bus.in_valid = 1'b0;
         vectors++;
         if ({bus.out_valid, bus.result, bus.zero, bus.co, bus.ovf} !== {1'b1, exps[i], zexp[i], 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL logic_op%0d: got v=%b r=%h z=%b co=%b ovf=%b want v=1 r=%h z=%b co=0 ovf=0",
                     ops[i], bus.out_valid, bus.result, bus.zero, bus.co, bus.ovf, exps[i], zexp[i]);
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_mul();
      int lat;
      int busy_bad;
      @(negedge clk);
      drive(1'b1, OP_MUL, 8'hFF, 8'hFF, 1'b0);
      @(negedge clk);
      // Keep a competing command present: it must be ignored while busy.
      drive(1'b1, OP_ADD, 8'h01, 8'h01, 1'b0);
      lat = 1;
      busy_bad = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         if (bus.in_ready !== 1'b0) busy_bad++;
         @(negedge clk);
         lat++;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (lat != 9) begin
         miscompares++;
         $display("FAIL mul_latency: got %0d cycles want 9", lat);
      end
      vectors++;
      if (busy_bad != 0) begin
         miscompares++;
         $display("FAIL mul_in_ready: got %0d busy cycles with in_ready=1 want 0", busy_bad);
      end
      vectors++;
      if ({bus.result, bus.result_hi, bus.co, bus.zero, bus.ovf} !== {8'h01, 8'hFE, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL mul_ff_ff: got r=%h hi=%h co=%b z=%b ovf=%b want r=01 hi=fe co=1 z=0 ovf=0",
                  bus.result, bus.result_hi, bus.co, bus.zero, bus.ovf);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      drive(1'b1, OP_ADD, 8'h03, 8'h04, 1'b0);
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if ({bus.out_valid, bus.result, bus.in_ready} !== {1'b1, 8'h07, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got v=%b r=%h in_ready=%b want v=1 r=07 in_ready=0",
                     i, bus.out_valid, bus.result, bus.in_ready);
         end
         @(negedge clk);
      end
      drive(1'b1, OP_XOR, 8'hF0, 8'hFF, 1'b0);
      bus.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_in_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.result, bus.zero} !== {1'b1, 8'h0F, 1'b0}) begin
         miscompares++;
         $display("FAIL bp_b2b_xor: got v=%b r=%h z=%b want v=1 r=0f z=0", bus.out_valid, bus.result, bus.zero);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      drive(1'b1, OP_MUL, 8'h12, 8'h34, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.out_valid, bus.result, bus.result_hi, bus.co, bus.zero, bus.ovf} !== 20'h0) begin
         miscompares++;
         $display("FAIL areset_outputs: got v=%b r=%h hi=%h co=%b z=%b ovf=%b want all 0",
                  bus.out_valid, bus.result, bus.result_hi, bus.co, bus.zero, bus.ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL areset_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      drive(1'b1, OP_ADD, 8'h01, 8'h01, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.result} !== {1'b1, 8'h02}) begin
         miscompares++;
         $display("FAIL areset_add: got v=%b r=%h want v=1 r=02", bus.out_valid, bus.result);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      // Multiplier must restart cleanly after an interrupted run.
      drive(1'b1, OP_MUL, 8'h03, 8'h05, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (8) @(negedge clk);
      vectors++;
      if ({bus.out_valid, bus.result, bus.result_hi, bus.co} !== {1'b1, 8'h0F, 8'h00, 1'b0}) begin
         miscompares++;
         $display("FAIL areset_mul: got v=%b r=%h hi=%h co=%b want v=1 r=0f hi=00 co=0",
                  bus.out_valid, bus.result, bus.result_hi, bus.co);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reserved();
      @(negedge clk);
      drive(1'b1, OP_RSVD, 8'h55, 8'hAA, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.result, bus.zero, bus.co, bus.ovf, bus.result_hi} !==
          {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL reserved_op: got v=%b r=%h z=%b co=%b ovf=%b hi=%h want v=1 r=00 z=1 co=0 ovf=0 hi=00",
                  bus.out_valid, bus.result, bus.zero, bus.co, bus.ovf, bus.result_hi);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

`ifdef ALU_PIPE_ACCUM_EN
   task automatic test_accum();
      @(negedge clk);
      drive(1'b1, OP_ADD, 8'h05, 8'h00, 1'b0);
      bus.acc_sel = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(1'b1, OP_ADD, 8'h77, 8'h03, 1'b0);
      bus.acc_sel = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.acc_sel = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.result} !== {1'b1, 8'h08}) begin
         miscompares++;
         $display("FAIL accum_add: got v=%b r=%h want v=1 r=08", bus.out_valid, bus.result);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask
`endif

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
`ifdef ALU_PIPE_ACCUM_EN
      bus.acc_sel = 1'b0;
`endif
      drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      test_reset();
      test_add();
      test_sub();
      test_logic_ops();
      test_mul();
      test_backpressure();
      test_async_reset();
      test_reserved();
`ifdef ALU_PIPE_ACCUM_EN
      test_accum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the 4-bit combinational add/zero ALU.
- Generalises to WIDTH bits and an 8-entry op set, adds an iterative shift-add multiply and a registered result with flags.
- Sits between an operand source and a result consumer, using valid/ready on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block can accept a command this cycle.
- op  in  3  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry in (ADD/SUB only).
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  low result word.
- result_hi  out  WIDTH  MUL high word; 0 for all other ops.
- co  out  1  carry out; for MUL, OR-reduce of result_hi.
- zero  out  1  result == 0 (low word only).
- ovf  out  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Ops:
  - 000 ZERO: result 0, preserves legacy select-0 behaviour.
  - 001 ADD: a+b+ci.
  - 010 SUB: a+~b+ci; ci=1 gives a-b.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 MUL: unsigned, {result_hi,result}=a*b.
  - 111 reserved: result 0, co=0, ovf=0, zero=1.
- Reset (async, any cycle including mid-MUL): state=IDLE, all outputs and internal registers 0, out_valid=0.
- FSM states IDLE, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready only.
- Accept = in_valid && in_ready. On accept, a, b, ci and op are captured.
- Non-MUL ops: result and flags registered on the accept edge, next state DONE. out_valid rises the cycle after accept (latency 1).
- MUL: next state MUL with counter=0. Each cycle, if multiplier bit[0] is set, add the multiplicand to the partial product, then shift.
- MUL exits to DONE after exactly WIDTH iterations. out_valid rises WIDTH+1 cycles after accept.
- In MUL, in_ready=0 and in_valid is ignored.
- DONE: out_valid=1. result, result_hi and flags are held stable while out_ready=0.
- DONE with out_ready=1 and no accept: go to IDLE, out_valid=0 next cycle.
- DONE with out_ready=1 and accept in the same cycle: load the new command directly, giving back-to-back throughput of one non-MUL op per cycle.
- Widths:
  - ADD/SUB use a WIDTH+1 internal sum; co = bit WIDTH.
  - ovf = (a[msb]==b'[msb]) && (sum[msb]!=a[msb]), where b' = b for ADD and ~b for SUB.
  - zero evaluates result only, never result_hi.
- Outputs not updated by the current op are written 0, so there is no stale data in DONE.

Optional Feature:
- Macro ALU_PIPE_ACCUM_EN.
- Defined:
  - Adds port acc_sel in 1.
  - On accept with acc_sel=1, operand A is replaced by the last delivered result (low word).
  - The accumulator register updates on each out_valid&&out_ready handshake and resets to 0.
- Undefined: no acc_sel port, no accumulator register; A is always the a port.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (3-bit, values above).
  - alu_state_e enum (IDLE, MUL, DONE).
  - OP_W=3 constant.
- Sub-module alu_shift_mul (WIDTH param):
  - Interface: start, a, b in; busy, done, prod[2*WIDTH] out.
  - Owns the counter and partial-product shift register.
- The top owns the FSM, single-cycle datapath, flags and handshake.

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01 ci=0 -> result=0x00, co=1, zero=1, ovf=0; out_valid exactly 1 cycle after accept.
- SUB a=0x80 b=0x01 ci=1 -> result=0x7F, co=1, ovf=1, zero=0, result_hi=0.
- MUL a=0xFF b=0xFF -> result=0x01, result_hi=0xFE, co=1; in_ready=0 for the MUL cycles; out_valid 9 cycles after accept.
- Backpressure: ADD 3+4, hold out_ready=0 for 5 cycles -> result=0x07 stable, in_ready=0. Then out_ready=1 with in_valid=1, op=XOR a=0xF0 b=0xFF -> accepted that cycle; next cycle result=0x0F.
- Async reset asserted 4 cycles into MUL 0x12*0x34 -> all outputs 0 immediately. After release: in_ready=1, out_valid=0; a new ADD 1+1 yields 0x02.
- op=111 a=0x55 b=0xAA -> result=0, zero=1, co=0, ovf=0. With ALU_PIPE_ACCUM_EN: ADD 5+0, then acc_sel=1 ADD b=3 -> 0x08.
